glitch_train: RTL and testbench
===============================

// Module: glitch_train
// PURPOSE
//  Parametrised successor to the single-shot glitch pulse generator. After an
//  optional external trigger it waits a holdoff, then emits a programmable
//  train of N pulses with programmable width, gap and polarity. It sits between
//  the control register block and the crowbar/supply-switch output pin.
//  Timing parameters are latched at train start, so the host can reprogram
//  them mid-train without affecting the train in flight.
// PARAMETERS
//  CNT_W    32  width of holdoff / pulse_width / gap counters
//  NP_W      8  width of pulse_count and pulse_idx (max 2**NP_W-1 pulses)
// PORTS
//  clk          in   1      system clock
//  rst_n        in   1      reset, asynchronous, active-low
//  armed        in   1      level; 1=run sequence, 0=abort/idle
//  use_trigger  in   1      1=wait for trigger rising edge; 0=start on arm
//  trigger      in   1      async external trigger, internally 2-FF synced
//  inverse      in   1      0=pulse active-low (idle high); 1=active-high
//  always_on    in   1      disarmed level: 1=idle level, 0=active level
//  holdoff      in   CNT_W  idle cycles from start to first pulse
//  pulse_width  in   CNT_W  active cycles per pulse
//  gap          in   CNT_W  idle cycles between consecutive pulses
//  pulse_count  in   NP_W   pulses per train
//  out          out  1      glitch output, registered
//  busy         out  1      high in HOLDOFF/PULSE/GAP
//  rdy          out  1      high in DONE until disarm
//  pulse_idx    out  NP_W   pulses completed in current train
// BEHAVIOUR
//  - Level definitions: ACT=inverse, IDL=~inverse.
//  - Reset (rst_n=0): state=IDLE, out=0, busy=0, rdy=0, pulse_idx=0,
//    sync flops=0, counter=0.
//  - States: IDLE, WAIT_TRIG, HOLDOFF, PULSE, GAP, DONE. All outputs registered.
//  - IDLE: out=always_on?IDL:ACT, counter=0, pulse_idx=0.
//    armed=1 -> WAIT_TRIG if use_trigger, else HOLDOFF.
//  - WAIT_TRIG: out=IDL. Synced-trigger rising edge -> HOLDOFF.
//    Pin edge to HOLDOFF entry takes 3 clk: 2 sync flops + 1 edge register.
//  - On entry to HOLDOFF, latch holdoff, pulse_width, gap and pulse_count.
//  - HOLDOFF: out=IDL for exactly holdoff cycles.
//    holdoff=0 -> zero cycles, i.e. PULSE on the next cycle.
//    latched pulse_count=0 -> DONE instead of PULSE.
//  - PULSE: out=ACT for exactly pulse_width cycles.
//    pulse_width=0 -> zero active cycles, but the pulse still counts.
//    At end: pulse_idx+=1; go to DONE if pulse_idx==pulse_count, else GAP.
//  - GAP: out=IDL for exactly gap cycles; gap=0 -> back-to-back pulses,
//    i.e. one merged active level.
//  - DONE: out=IDL, rdy=1. Stays until armed=0. No retrigger while armed.
//  - Timing reference S = first cycle in HOLDOFF. Pulse k (0-based) is active
//    on cycles S+holdoff+k*(pulse_width+gap) through
//    S+holdoff+k*(pulse_width+gap)+pulse_width-1.
//  - Counters: CNT_W-bit, compare before increment; no wrap is possible.
//  - Abort: armed=0 in any state -> IDLE next clock. out takes the disarmed
//    level and busy, rdy, pulse_idx clear on that same edge.
//  - Trigger edges are ignored outside WAIT_TRIG.
//    Edge and arm in the same cycle: the edge is ignored (WAIT_TRIG entered after).
//  - Live input changes after HOLDOFF entry have no effect except armed,
//    always_on and inverse. inverse is not latched; changing it mid-train is
//    allowed but glitchy and is a software error.
// TESTING
//  1. rst_n=0 mid-PULSE -> out=0, busy=0, rdy=0, pulse_idx=0 immediately (async).
//  2. use_trigger=0, holdoff=5, pw=3, gap=2, count=3, inverse=0 -> out low
//     S+5..7, S+10..12, S+15..17; rdy=1 from S+18; pulse_idx=3.
//  3. use_trigger=1, trigger pulse on pin -> HOLDOFF entered 3 clk later; a
//     second trigger mid-train is ignored.
//  4. holdoff=0, pw=0, count=2 -> out never active; DONE reached; pulse_idx=2.
//     count=0 -> DONE straight from HOLDOFF, no pulse.
//  5. armed dropped in GAP with always_on=1 -> next clk out=1 (IDL),
//     state=IDLE; re-arm starts a fresh train from pulse_idx=0.
//  6. inverse=1, gap=0, pw=2, count=2 -> out high 4 consecutive cycles;
//     reprogramming pw mid-train does not alter the train.

Source files
------------

// File: rtl/glitch_train_if.sv
// Control/status bundle between the register block and the glitch train generator.
// The master drives the programming and arm controls; the slave returns the output pin and status.
interface glitch_train_if #(
  parameter int CNT_W = 32,
  parameter int NP_W  = 8
);
  logic             armed;
  logic             use_trigger;
  logic             trigger;
  logic             inverse;
  logic             always_on;
  logic [CNT_W-1:0] holdoff;
  logic [CNT_W-1:0] pulse_width;
  logic [CNT_W-1:0] gap;
  logic [NP_W-1:0]  pulse_count;
  logic             out;
  logic             busy;
  logic             rdy;
  logic [NP_W-1:0]  pulse_idx;

  modport master (
    output armed, use_trigger, trigger, inverse, always_on,
    output holdoff, pulse_width, gap, pulse_count,
    input  out, busy, rdy, pulse_idx
  );

  modport slave (
    input  armed, use_trigger, trigger, inverse, always_on,
    input  holdoff, pulse_width, gap, pulse_count,
    output out, busy, rdy, pulse_idx
  );
endinterface

// File: rtl/glitch_train.sv
// Armed/triggered pulse-train generator: holdoff, then N pulses of programmable width/gap.
// All outputs registered; trigger pin to HOLDOFF entry is 3 clk; no backpressure, armed=0 aborts.
module glitch_train #(
  parameter int CNT_W = 32,
  parameter int NP_W  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  glitch_train_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TRIG,
    S_HOLDOFF,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ho_q, ho_d;
  logic [CNT_W-1:0] pw_q, pw_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [NP_W-1:0]  np_q, np_d;
  logic [NP_W-1:0]  idx_q, idx_d;
  logic [NP_W-1:0]  idx_inc;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             rdy_q, rdy_d;
  logic             trig_s1_q, trig_s2_q, trig_s3_q;
  logic             trig_edge;
  logic             start, hold_end, pulse_end;

  assign trig_edge = trig_s2_q & ~trig_s3_q;
  assign idx_inc   = idx_q + NP_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_s1_q <= 1'b0;
      trig_s2_q <= 1'b0;
      trig_s3_q <= 1'b0;
    end else begin
      trig_s1_q <= bus.trigger;
      trig_s2_q <= trig_s1_q;
      trig_s3_q <= trig_s2_q;
    end
  end

  // Zero-length holdoff and gap phases are skipped on the entering edge so the
  // pin timing stays exact; PULSE always occupies at least one cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ho_d      = ho_q;
    pw_d      = pw_q;
    gap_d     = gap_q;
    np_d      = np_q;
    idx_d     = idx_q;
    start     = 1'b0;
    hold_end  = 1'b0;
    pulse_end = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (bus.armed) begin
          if (bus.use_trigger) state_d = S_WAIT_TRIG;
          else                 start   = 1'b1;
        end
      end
      S_WAIT_TRIG: begin
        if (trig_edge) start = 1'b1;
      end
      S_HOLDOFF: begin
        if (cnt_q == ho_q - CNT_W'(1)) hold_end = 1'b1;
        else                           cnt_d    = cnt_q + CNT_W'(1);
      end
      S_PULSE: begin
        if (pw_q == '0 || cnt_q == pw_q - CNT_W'(1)) pulse_end = 1'b1;
        else                                         cnt_d     = cnt_q + CNT_W'(1);
      end
      S_GAP: begin
        if (cnt_q == gap_q - CNT_W'(1)) begin
          state_d = S_PULSE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      ho_d  = bus.holdoff;
      pw_d  = bus.pulse_width;
      gap_d = bus.gap;
      np_d  = bus.pulse_count;
      cnt_d = '0;
      if (bus.holdoff != '0)          state_d = S_HOLDOFF;
      else if (bus.pulse_count == '0) state_d = S_DONE;
      else                            state_d = S_PULSE;
    end

    if (hold_end) begin
      cnt_d   = '0;
      state_d = (np_q == '0) ? S_DONE : S_PULSE;
    end

    if (pulse_end) begin
      cnt_d = '0;
      idx_d = idx_inc;
      if (idx_inc == np_q)  state_d = S_DONE;
      else if (gap_q == '0) state_d = S_PULSE;
      else                  state_d = S_GAP;
    end

    if (!bus.armed) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end

    busy_d = (state_d == S_HOLDOFF) || (state_d == S_PULSE) || (state_d == S_GAP);
    rdy_d  = (state_d == S_DONE);
    if (state_d == S_IDLE)                     out_d = bus.always_on ? ~bus.inverse : bus.inverse;
    else if (state_d == S_PULSE && pw_d != '0) out_d = bus.inverse;
    else                                       out_d = ~bus.inverse;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ho_q    <= '0;
      pw_q    <= '0;
      gap_q   <= '0;
      np_q    <= '0;
      idx_q   <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ho_q    <= ho_d;
      pw_q    <= pw_d;
      gap_q   <= gap_d;
      np_q    <= np_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.busy      = busy_q;
  assign bus.rdy       = rdy_q;
  assign bus.pulse_idx = idx_q;

endmodule

// File: tb/tb_glitch_train.sv
// Bench for glitch_train: directed scenarios plus randomized trains against a timing-formula model.
module tb_glitch_train;
  localparam int CNT_W = 32;
  localparam int NP_W  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  glitch_train_if #(.CNT_W(CNT_W), .NP_W(NP_W)) bus ();
  glitch_train #(.CNT_W(CNT_W), .NP_W(NP_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Pulse k is active on [ho + k*(pw+gap), ho + k*(pw+gap) + pw), t counted from the start cycle.
  function automatic bit m_active(input int t, input int ho, input int pw, input int gap, input int np);
    int s;
    for (int k = 0; k < np; k++) begin
      s = ho + k * (pw + gap);
      if (t >= s && t < s + pw) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int m_done(input int ho, input int pw, input int gap, input int np);
    if (np == 0) return ho;
    return ho + np * pw + (np - 1) * gap;
  endfunction

  task automatic setup(input int ho, input int pw, input int gap, input int np,
                       input bit inv, input bit aon, input bit utr);
    bus.holdoff     = CNT_W'(ho);
    bus.pulse_width = CNT_W'(pw);
    bus.gap         = CNT_W'(gap);
    bus.pulse_count = NP_W'(np);
    bus.inverse     = inv;
    bus.always_on   = aon;
    bus.use_trigger = utr;
  endtask

  task automatic disarm();
    @(negedge clk);
    bus.armed = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bus.out, bus.busy, bus.rdy, bus.pulse_idx} !== {3'b000, NP_W'(0)}) begin
      errors++;
      $display("FAIL reset_state out/busy/rdy=%b%b%b idx=%0d expected 000 idx=0",
               bus.out, bus.busy, bus.rdy, bus.pulse_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out !== 1'b1) begin
      errors++;
      $display("FAIL idle_level out=%b expected 1", bus.out);
    end
  endtask

  task automatic test_spec_train();
    bit eo, eb, er;
    int td;
    setup(5, 3, 2, 3, 1'b0, 1'b1, 1'b0);
    td = m_done(5, 3, 2, 3);
    @(negedge clk);
    bus.armed = 1'b1;
    for (int t = 0; t <= td + 2; t++) begin
      @(negedge clk);
      eo = m_active(t, 5, 3, 2, 3) ? 1'b0 : 1'b1;
      eb = (t < td);
      er = (t >= td);
      checks++;
      if ({bus.out, bus.busy, bus.rdy} !== {eo, eb, er}) begin
        errors++;
        $display("FAIL spec_train t=%0d out/busy/rdy=%b%b%b expected %b%b%b",
                 t, bus.out, bus.busy, bus.rdy, eo, eb, er);
      end
    end
    checks++;
    if (bus.pulse_idx !== NP_W'(3)) begin
      errors++;
      $display("FAIL spec_train_idx got=%0d expected 3", bus.pulse_idx);
    end
    disarm();
  endtask

  task automatic test_trigger();
    bit eo, eb, er;
    int td;
    setup(3, 2, 2, 3, 1'b0, 1'b1, 1'b1);
    td = m_done(3, 2, 2, 3);
    @(negedge clk);
    bus.armed = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.out, bus.busy} !== 2'b10) begin
        errors++;
        $display("FAIL trig_wait cyc=%0d out/busy=%b%b expected 10", i, bus.out, bus.busy);
      end
    end
    bus.trigger = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL trig_latency_early cyc=%0d busy=%b expected 0", i, bus.busy);
      end
    end
    for (int t = 0; t <= td + 2; t++) begin
      @(negedge clk);
      if (t == 0) bus.trigger = 1'b0;
      eo = m_active(t, 3, 2, 2, 3) ? 1'b0 : 1'b1;
      eb = (t < td);
      er = (t >= td);
      checks++;
      if ({bus.out, bus.busy, bus.rdy} !== {eo, eb, er}) begin
        errors++;
        $display("FAIL trig_train t=%0d out/busy/rdy=%b%b%b expected %b%b%b",
                 t, bus.out, bus.busy, bus.rdy, eo, eb, er);
      end
      if (t == 4) bus.trigger = 1'b1;
      if (t == 7) bus.trigger = 1'b0;
    end
    checks++;
    if (bus.pulse_idx !== NP_W'(3)) begin
      errors++;
      $display("FAIL trig_idx got=%0d expected 3", bus.pulse_idx);
    end
    disarm();
  endtask

  task automatic test_zero_lengths();
    bit eo, eb, er;
    int td;
    bit seen;
    setup(0, 0, 1, 2, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    bus.armed = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      checks++;
      if (bus.out !== 1'b1) begin
        errors++;
        $display("FAIL zero_pw_out t=%0d out=%b expected 1", t, bus.out);
      end
      seen = bus.rdy;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL zero_pw_done rdy=%b expected 1 within 40 cycles", bus.rdy);
    end
    checks++;
    if (bus.pulse_idx !== NP_W'(2)) begin
      errors++;
      $display("FAIL zero_pw_idx got=%0d expected 2", bus.pulse_idx);
    end
    disarm();

    setup(3, 2, 1, 0, 1'b0, 1'b1, 1'b0);
    td = m_done(3, 2, 1, 0);
    @(negedge clk);
    bus.armed = 1'b1;
    for (int t = 0; t <= td + 2; t++) begin
      @(negedge clk);
      eo = m_active(t, 3, 2, 1, 0) ? 1'b0 : 1'b1;
      eb = (t < td);
      er = (t >= td);
      checks++;
      if ({bus.out, bus.busy, bus.rdy} !== {eo, eb, er}) begin
        errors++;
        $display("FAIL zero_count t=%0d out/busy/rdy=%b%b%b expected %b%b%b",
                 t, bus.out, bus.busy, bus.rdy, eo, eb, er);
      end
    end
    checks++;
    if (bus.pulse_idx !== NP_W'(0)) begin
      errors++;
      $display("FAIL zero_count_idx got=%0d expected 0", bus.pulse_idx);
    end
    disarm();
  endtask

  task automatic test_abort();
    bit eo, eb, er;
    int td;
    setup(1, 2, 5, 3, 1'b0, 1'b1, 1'b0);
    td = m_done(1, 2, 5, 3);
    @(negedge clk);
    bus.armed = 1'b1;
    for (int t = 0; t <= 4; t++) begin
      @(negedge clk);
      eo = m_active(t, 1, 2, 5, 3) ? 1'b0 : 1'b1;
      checks++;
      if ({bus.out, bus.busy} !== {eo, 1'b1}) begin
        errors++;
        $display("FAIL abort_pre t=%0d out/busy=%b%b expected %b1", t, bus.out, bus.busy, eo);
      end
    end
    checks++;
    if (bus.pulse_idx !== NP_W'(1)) begin
      errors++;
      $display("FAIL abort_mid_idx got=%0d expected 1", bus.pulse_idx);
    end
    bus.armed = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.out, bus.busy, bus.rdy, bus.pulse_idx} !== {3'b100, NP_W'(0)}) begin
      errors++;
      $display("FAIL abort_gap out/busy/rdy=%b%b%b idx=%0d expected 100 idx=0",
               bus.out, bus.busy, bus.rdy, bus.pulse_idx);
    end
    bus.armed = 1'b1;
    for (int t = 0; t <= td + 2; t++) begin
      @(negedge clk);
      eo = m_active(t, 1, 2, 5, 3) ? 1'b0 : 1'b1;
      eb = (t < td);
      er = (t >= td);
      checks++;
      if ({bus.out, bus.busy, bus.rdy} !== {eo, eb, er}) begin
        errors++;
        $display("FAIL rearm_train t=%0d out/busy/rdy=%b%b%b expected %b%b%b",
                 t, bus.out, bus.busy, bus.rdy, eo, eb, er);
      end
    end
    checks++;
    if (bus.pulse_idx !== NP_W'(3)) begin
      errors++;
      $display("FAIL rearm_idx got=%0d expected 3", bus.pulse_idx);
    end
    disarm();
  endtask

  task automatic test_back_to_back();
    bit eo, eb, er;
    int td;
    setup(1, 2, 0, 2, 1'b1, 1'b1, 1'b0);
    td = m_done(1, 2, 0, 2);
    @(negedge clk);
    bus.armed = 1'b1;
    for (int t = 0; t <= td + 2; t++) begin
      @(negedge clk);
      if (t == 1) begin
        bus.pulse_width = CNT_W'(7);
        bus.gap         = CNT_W'(3);
        bus.pulse_count = NP_W'(5);
      end
      eo = m_active(t, 1, 2, 0, 2) ? 1'b1 : 1'b0;
      eb = (t < td);
      er = (t >= td);
      checks++;
      if ({bus.out, bus.busy, bus.rdy} !== {eo, eb, er}) begin
        errors++;
        $display("FAIL back_to_back t=%0d out/busy/rdy=%b%b%b expected %b%b%b",
                 t, bus.out, bus.busy, bus.rdy, eo, eb, er);
      end
    end
    checks++;
    if (bus.pulse_idx !== NP_W'(2)) begin
      errors++;
      $display("FAIL back_to_back_idx got=%0d expected 2", bus.pulse_idx);
    end
    disarm();
  endtask

  task automatic test_random();
    bit eo, eb, er, inv, aon;
    int ho, pw, gp, np, td;
    for (int n = 0; n < 8; n++) begin
      ho  = $urandom_range(0, 6);
      pw  = $urandom_range(1, 4);
      gp  = $urandom_range(0, 3);
      np  = $urandom_range(0, 4);
      inv = 1'($urandom_range(0, 1));
      aon = 1'($urandom_range(0, 1));
      setup(ho, pw, gp, np, inv, aon, 1'b0);
      td = m_done(ho, pw, gp, np);
      @(negedge clk);
      bus.armed = 1'b1;
      for (int t = 0; t <= td + 2; t++) begin
        @(negedge clk);
        eo = m_active(t, ho, pw, gp, np) ? inv : ~inv;
        eb = (t < td);
        er = (t >= td);
        checks++;
        if ({bus.out, bus.busy, bus.rdy} !== {eo, eb, er}) begin
          errors++;
          $display("FAIL rand%0d t=%0d ho=%0d pw=%0d gap=%0d n=%0d out/busy/rdy=%b%b%b expected %b%b%b",
                   n, t, ho, pw, gp, np, bus.out, bus.busy, bus.rdy, eo, eb, er);
        end
      end
      checks++;
      if (bus.pulse_idx !== NP_W'(np)) begin
        errors++;
        $display("FAIL rand%0d_idx got=%0d expected %0d", n, bus.pulse_idx, np);
      end
      disarm();
      eo = aon ? ~inv : inv;
      checks++;
      if ({bus.out, bus.busy, bus.rdy, bus.pulse_idx} !== {eo, 2'b00, NP_W'(0)}) begin
        errors++;
        $display("FAIL rand%0d_disarm out/busy/rdy=%b%b%b idx=%0d expected %b00 idx=0",
                 n, bus.out, bus.busy, bus.rdy, bus.pulse_idx, eo);
      end
    end
  endtask

  task automatic test_async_reset();
    setup(2, 10, 1, 1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    bus.armed = 1'b1;
    for (int t = 0; t <= 3; t++) @(negedge clk);
    checks++;
    if ({bus.out, bus.busy} !== 2'b01) begin
      errors++;
      $display("FAIL async_pre out/busy=%b%b expected 01", bus.out, bus.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out, bus.busy, bus.rdy, bus.pulse_idx} !== {3'b000, NP_W'(0)}) begin
      errors++;
      $display("FAIL async_reset out/busy/rdy=%b%b%b idx=%0d expected 000 idx=0",
               bus.out, bus.busy, bus.rdy, bus.pulse_idx);
    end
    @(negedge clk);
    bus.armed = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bus.armed = 1'b0;
    bus.trigger = 1'b0;
    setup(0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    test_reset();
    test_spec_train();
    test_trigger();
    test_zero_lengths();
    test_abort();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
